// File: rtl/dvs_fifo_pkg.sv
// Shared types and helpers for the DVS event FIFO serializer.
// No logic; consumed by the top and the lane shifter.
// No flow control of its own.
package dvs_fifo_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam int DROP_CNT_W = 16;

    // Number of LANE_W beats needed to carry one event word.
    function automatic int beats(input int dw, input int lw);
        return dw / lw;
    endfunction

endpackage

// File: rtl/dvs_lane_shifter.sv
// Holds the word being streamed and presents it MSB-first, one LANE_W beat at a time.
// Latency: a loaded word shows its first beat the cycle after load.
// Backpressure: beat, last flag and channel tag hold while shift_en is low.
module dvs_lane_shifter
    import dvs_fifo_pkg::*;
#(
    parameter int DWIDTH = 136,
    parameter int LANE_W = 4,
    parameter int CHW    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DWIDTH-1:0] load_dat,
    input  logic [CHW-1:0]    load_ch,
    input  logic              shift_en,
    output logic [LANE_W-1:0] out_data,
    output logic              out_last,
    output logic [CHW-1:0]    out_ch
);

    localparam int BEATS = beats(DWIDTH, LANE_W);
    localparam int CW    = $clog2(BEATS + 1);

    logic [DWIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [CHW-1:0]    ch_q, ch_d;

    // A load (new word) takes priority over shifting the word just finished.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ch_d    = ch_q;
        if (load) begin
            shift_d = load_dat;
            cnt_d   = '0;
            last_d  = (BEATS == 1);
            ch_d    = load_ch;
        end else if (shift_en) begin
            shift_d = shift_q << LANE_W;
            cnt_d   = cnt_q + CW'(1);
            last_d  = ((cnt_q + CW'(1)) == CW'(BEATS - 1));
        end
    end

    // Shift register, beat counter and registered last flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            ch_q    <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
        end
    end

    assign out_data = shift_q[DWIDTH-1 -: LANE_W];
    assign out_last = last_q;
    assign out_ch   = ch_q;

endmodule

// File: rtl/dvs_evt_fifo_serializer.sv
// Multi-channel event FIFO feeding a LANE_W-wide serial stream; optional drop counter under DVS_FIFO_DROP_CNT_EN.
// Latency: first beat one cycle after the head becomes visible; words stream back-to-back with no bubble.
// Backpressure: out_ready stalls the stream; writers are never stalled, excess words are dropped and flagged in ovf.
module dvs_evt_fifo_serializer
    import dvs_fifo_pkg::*;
#(
    parameter  int DWIDTH    = 136,
    parameter  int DEPTH     = 16,
    parameter  int NUM_CH    = 2,
    parameter  int LANE_W    = 4,
    parameter  int AFULL_LVL = 12,
    localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int NW        = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [NUM_CH*DWIDTH-1:0] wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANE_W-1:0]        out_data,
    output logic                     out_last,
    output logic [CHW-1:0]           out_ch,
    output logic [NW-1:0]            numel,
    output logic                     empty,
    output logic                     full,
    output logic                     afull,
    output logic [NUM_CH-1:0]        ovf,
`ifdef DVS_FIFO_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0]    drop_cnt,
`endif
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [CHW-1:0]    tag_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]     numel_q, numel_d;
    logic              empty_q, empty_d, full_q, full_d, afull_q, afull_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    state_e            state_q, state_d;

    logic [NUM_CH-1:0] wr_acc, wr_drop;
    logic [AW-1:0]     wr_addr [NUM_CH];
    logic [NW-1:0]     acc_cnt, free;
    logic              pop, accept, sh_last;

    // Grant writes in ascending channel order against space counted before any pop.
    always_comb begin
        free    = NW'(DEPTH) - numel_q;
        acc_cnt = '0;
        wr_acc  = '0;
        wr_drop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_addr[c] = wr_ptr_q + acc_cnt[AW-1:0];
            if (wr_en[c]) begin
                if (acc_cnt < free) begin
                    wr_acc[c] = 1'b1;
                    acc_cnt   = acc_cnt + NW'(1);
                end else begin
                    wr_drop[c] = 1'b1;
                end
            end
        end
    end

    // Pop/stream control: pop on idle with data, or chain the next word on the last beat.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        accept  = (state_q == STREAM) && out_ready;
        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept && sh_last) begin
                    if (!empty_q) pop = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer, occupancy, flag and sticky overflow next-state; a new drop beats ovf_clr.
    always_comb begin
        wr_ptr_d = wr_ptr_q + acc_cnt[AW-1:0];
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        numel_d  = numel_q + acc_cnt - NW'(pop);
        empty_d  = (numel_d == '0);
        full_d   = (numel_d == NW'(DEPTH));
        afull_d  = (numel_d >= NW'(AFULL_LVL));
        ovf_d    = (ovf_clr ? '0 : ovf_q) | wr_drop;
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            numel_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= '0;
            state_q  <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            numel_q  <= numel_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end

    // Event storage with channel tags; contents survive reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_acc[c]) begin
                mem_q[wr_addr[c]] <= wdata[c*DWIDTH +: DWIDTH];
                tag_q[wr_addr[c]] <= CHW'(c);
            end
        end
    end

`ifdef DVS_FIFO_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_CNT_W:0]   drop_sum;
    logic [DROP_CNT_W:0]   drop_num;

    // Saturating total of dropped words; ovf_clr restarts the count from this cycle's drops.
    always_comb begin
        drop_num = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            drop_num = drop_num + {{DROP_CNT_W{1'b0}}, wr_drop[c]};
        end
        drop_sum = {1'b0, drop_cnt_q} + drop_num;
        if (ovf_clr)                drop_cnt_d = drop_num[DROP_CNT_W-1:0];
        else if (drop_sum[DROP_CNT_W]) drop_cnt_d = '1;
        else                        drop_cnt_d = drop_sum[DROP_CNT_W-1:0];
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

    dvs_lane_shifter #(
        .DWIDTH (DWIDTH),
        .LANE_W (LANE_W),
        .CHW    (CHW)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pop),
        .load_dat (mem_q[rd_ptr_q]),
        .load_ch  (tag_q[rd_ptr_q]),
        .shift_en (accept),
        .out_data (out_data),
        .out_last (sh_last),
        .out_ch   (out_ch)
    );

    assign out_valid = (state_q == STREAM);
    assign out_last  = sh_last;
    assign numel     = numel_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign afull     = afull_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dvs_evt_fifo_serializer.sv
// Directed bench for dvs_evt_fifo_serializer with a queue-based reference model.
// Model advances on each rising edge; outputs are compared on every falling edge.
// Stimulus covers fill/drain, drops, backpressure, wrap-around, watermark and reset.
module tb_dvs_evt_fifo_serializer;

    localparam int DW    = 136;
    localparam int DEPTH = 16;
    localparam int NCH   = 2;
    localparam int LW    = 4;
    localparam int AFL   = 12;
    localparam int BEATS = DW / LW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NCH-1:0]  wr_en = '0;
    logic [NCH*DW-1:0] wdata = '0;
    logic            out_ready = 1'b0;
    logic            ovf_clr = 1'b0;
    logic            out_valid, out_last, empty, full, afull;
    logic [LW-1:0]   out_data;
    logic [0:0]      out_ch;
    logic [4:0]      numel;
    logic [NCH-1:0]  ovf;
`ifdef DVS_FIFO_DROP_CNT_EN
    logic [15:0]     drop_cnt;
`endif

    always #5 clk = ~clk;

    dvs_evt_fifo_serializer #(
        .DWIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH), .LANE_W(LW), .AFULL_LVL(AFL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wdata     (wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .numel     (numel),
        .empty     (empty),
        .full      (full),
        .afull     (afull),
        .ovf       (ovf),
`ifdef DVS_FIFO_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .ovf_clr   (ovf_clr)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          ch;
        logic [DW-1:0] w;
    } ent_t;

    ent_t          mq[$];
    logic          m_vld = 1'b0;
    logic [DW-1:0] m_word = '0;
    logic          m_ch = 1'b0;
    int            m_beat = 0;
    logic [1:0]    m_ovf = '0;
    int            m_drop = 0;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        int n, free, acc, nd;
        logic [1:0] dropv;
        bit last_acc;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_vld = 1'b0; m_word = '0; m_ch = 1'b0; m_beat = 0;
            m_ovf = '0; m_drop = 0; chk_en = 1'b1;
        end else begin
            n = mq.size();
            free = DEPTH - n;
            last_acc = m_vld && out_ready && (m_beat == BEATS - 1);
            if (m_vld && out_ready) m_beat++;
            if (!m_vld || last_acc) begin
                if (n > 0) begin
                    e = mq.pop_front();
                    m_word = e.w; m_ch = e.ch; m_beat = 0; m_vld = 1'b1;
                end else begin
                    m_vld = 1'b0;
                end
            end
            acc = 0; nd = 0; dropv = '0;
            for (int c = 0; c < NCH; c++) begin
                if (wr_en[c]) begin
                    if (acc < free) begin
                        e.ch = 1'(c);
                        e.w = wdata[c*DW +: DW];
                        mq.push_back(e);
                        acc++;
                    end else begin
                        dropv[c] = 1'b1;
                        nd++;
                    end
                end
            end
            m_ovf = (ovf_clr ? 2'b00 : m_ovf) | dropv;
            m_drop = ovf_clr ? nd : ((m_drop + nd > 65535) ? 65535 : m_drop + nd);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [LW-1:0] ed;
        if (chk_en) begin
            chk("out_valid", out_valid, m_vld);
            chk("numel", numel, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == DEPTH);
            chk("afull", afull, mq.size() >= AFL);
            chk("ovf", ovf, m_ovf);
`ifdef DVS_FIFO_DROP_CNT_EN
            chk("drop_cnt", drop_cnt, m_drop);
`endif
            if (m_vld) begin
                ed = m_word[DW-1-LW*m_beat -: LW];
                chk("out_data", out_data, ed);
                chk("out_last", out_last, m_beat == BEATS - 1);
                chk("out_ch", out_ch, m_ch);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] mkw(input int i);
        logic [7:0] b;
        logic [DW-1:0] w;
        b = 8'(i);
        w = '0;
        w[135:132] = 4'hC;
        w[131:8] = {31{b[3:0]}};
        w[7:0] = b;
        return w;
    endfunction

    task automatic drive(input logic [1:0] en, input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        wr_en = en;
        wdata = {w1, w0};
        @(negedge clk);
        wr_en = '0;
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string nm);
        int k;
        k = 0;
        while (!(empty && !out_valid) && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (k >= lim) timeout(nm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats_n, lasts_n, gaps_n, bad0, k, ch1_lasts, maxn, nb;
        logic [LW-1:0] first_dat;

        // Reset values
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_numel", numel, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", afull, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill and drain, ready held high
        out_ready = 1'b1;
        beats_n = 0; lasts_n = 0; gaps_n = 0; bad0 = 0; first_dat = '0;
        fork
            begin
                for (int i = 0; i < 16; i++) drive(2'b01, mkw(i), '0);
            end
            begin
                for (int j = 0; j < 1000; j++) begin
                    if (out_valid && out_ready) begin
                        beats_n++;
                        if (beats_n == 1) first_dat = out_data;
                        if (((beats_n - 1) % BEATS == 0) && out_data !== 4'hC) bad0++;
                        if (out_last) lasts_n++;
                    end else if (beats_n > 0) begin
                        gaps_n++;
                    end
                    if (beats_n == 16 * BEATS) break;
                    @(negedge clk);
                end
            end
        join
        chk("fill_beats", beats_n, 544);
        chk("fill_lasts", lasts_n, 16);
        chk("fill_gaps", gaps_n, 0);
        chk("fill_first_beat", first_dat, 4'hC);
        chk("fill_beat0_each_word", bad0, 0);
        @(negedge clk);
        chk("drain_empty", empty, 1);
        chk("drain_valid", out_valid, 0);

        // Dual write at numel 15
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) drive(2'b01, mkw(100 + i), '0);
        chk("dual_pre_numel", numel, 15);
        drive(2'b11, mkw(200), mkw(201));
        chk("dual_numel", numel, 16);
        chk("dual_full", full, 1);
        chk("dual_ovf", ovf, 2'b10);
        pulse_clr();
        chk("dual_ovf_clr", ovf, 2'b00);

        // Write while popping at full: dropped
        out_ready = 1'b1;
        k = 0;
        while (!(out_valid && out_last) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) timeout("popfull_wait_last");
        drive(2'b01, mkw(300), '0);
        chk("popfull_numel", numel, 15);
        chk("popfull_ovf", ovf, 2'b01);
        pulse_clr();
        wait_idle(1000, "popfull_drain");

        // Backpressure with alternating ready
        lasts_n = 0; ch1_lasts = 0;
        fork
            begin
                drive(2'b10, mkw(400), mkw(401));
                drive(2'b01, mkw(402), '0);
                drive(2'b11, mkw(403), mkw(404));
            end
            begin
                for (int j = 0; j < 600; j++) begin
                    if (out_valid && out_ready && out_last) begin
                        lasts_n++;
                        if (out_ch == 1'b1) ch1_lasts++;
                    end
                    if (lasts_n == 4) break;
                    @(negedge clk);
                    out_ready = ~out_ready;
                end
            end
        join
        chk("bp_words", lasts_n, 4);
        chk("bp_ch1_words", ch1_lasts, 2);
        out_ready = 1'b1;
        wait_idle(100, "bp_drain");

        // Wrap-around: 40 spaced writes
        maxn = 0;
        for (int i = 0; i < 40; i++) begin
            drive((i % 2) ? 2'b10 : 2'b01, mkw(500 + i), mkw(500 + i));
            for (int j = 0; j < 39; j++) begin
                if (int'(numel) > maxn) maxn = int'(numel);
                @(negedge clk);
            end
        end
        chk("wrap_max_numel", maxn, 1);
        wait_idle(100, "wrap_drain");

        // Almost-full watermark
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) drive(2'b01, mkw(600 + i), '0);
        chk("afull_numel11", numel, 11);
        chk("afull_at11", afull, 0);
        drive(2'b01, mkw(612), '0);
        chk("afull_numel12", numel, 12);
        chk("afull_at12", afull, 1);

        // Three drops, then reset mid-stream at beat 10
        drive(2'b11, mkw(620), mkw(621));
        drive(2'b11, mkw(622), mkw(623));
        drive(2'b11, mkw(624), mkw(625));
        drive(2'b01, mkw(626), '0);
        chk("drops_ovf", ovf, 2'b11);
        chk("drops_full", full, 1);
`ifdef DVS_FIFO_DROP_CNT_EN
        chk("drops_cnt3", drop_cnt, 3);
`endif
        out_ready = 1'b1;
        nb = 0;
        k = 0;
        while (k < 100) begin
            if (out_valid && out_ready) begin
                if (nb == 10) break;
                nb++;
            end
            @(negedge clk);
            k++;
        end
        if (k >= 100) timeout("rst_mid_wait");
        rst_n = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_numel", numel, 0);
        chk("rstmid_empty", empty, 1);
        chk("rstmid_ovf", ovf, 0);
`ifdef DVS_FIFO_DROP_CNT_EN
        chk("rstmid_drop_cnt", drop_cnt, 0);
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dvs_evt_fifo_serializer.md
Name: dvs_evt_fifo_serializer

Overview:
- Multi-channel event FIFO with a narrow-lane serializer; it generalises the existing single-port 136-bit SPI FIFO register file.
- NUM_CH pixel-readout channels can write full-width event words in the same cycle. Words are stored in arrival order with a channel tag.
- Each word is streamed out MSB-first in LANE_W-bit beats over valid/ready. The SPI or pad-side block drains that stream in the clk domain.
- Adds multi-write, almost-full watermark, sticky overflow and back-to-back streaming.

Parameters:
DWIDTH, 136, event word width; must be a multiple of LANE_W
DEPTH, 16, FIFO entries; power of 2, >= NUM_CH
NUM_CH, 2, write channels (1..4)
LANE_W, 4, output beat width (1, 2, 4 or 8)
AFULL_LVL, 12, numel threshold for afull; 1..DEPTH

Ports:
clk  in  1  system clock
rst_n  in  1  reset
wr_en  in  NUM_CH  per-channel write strobe; no backpressure
wdata  in  NUM_CH*DWIDTH  channel c occupies bits [c*DWIDTH +: DWIDTH]
out_valid  out  1  beat valid
out_ready  in  1  beat accepted when valid&&ready
out_data  out  LANE_W  current beat
out_last  out  1  final beat of word
out_ch  out  max(1,$clog2(NUM_CH))  channel tag of word being streamed; stable for all beats
numel  out  $clog2(DEPTH)+1  stored words, 0..DEPTH inclusive
empty  out  1  numel==0
full  out  1  numel==DEPTH
afull  out  1  numel>=AFULL_LVL
ovf  out  NUM_CH  sticky, per channel: a write was dropped
ovf_clr  in  1  clears ovf

Behaviour:
- Reset: one clock, synchronous active-low reset rst_n on clk.
  - Pointers, numel, FSM, shift register and beat counter go to 0.
  - Outputs after reset: out_valid=0, out_last=0, out_data=0, out_ch=0, numel=0, empty=1, full=0, afull=0, ovf=0.
  - Memory contents are not reset.
- Writes, each cycle:
  - free = DEPTH - numel, sampled before this cycle's pop; a same-cycle pop does not create space.
  - Asserted channels are accepted in ascending channel index, up to free.
  - Accepted words go to wr_ptr, wr_ptr+1, ... with pointers mod DEPTH, tagged with the channel index.
  - Excess channels are dropped and set ovf[c].
  - If ovf_clr and a new drop for the same channel occur in one cycle, set wins.
- Pop and stream FSM, states IDLE, STREAM:
  - IDLE, !empty: pop head into the shift register, set out_ch, beat_cnt=0, go to STREAM. out_valid rises the next cycle (1-cycle latency from a non-empty head).
  - IDLE, empty: stay in IDLE, out_valid=0.
  - STREAM:
    - out_data = shift[DWIDTH-1 -: LANE_W].
    - On accept: shift left by LANE_W and increment beat_cnt.
    - out_last = (beat_cnt == DWIDTH/LANE_W - 1).
  - Last beat accepted, FIFO non-empty: pop next word in the same cycle and stay in STREAM. No bubble between words.
  - Last beat accepted, FIFO empty: go to IDLE.
  - out_ready low holds out_data, out_last and out_ch stable.
- numel next = numel + accepted_writes - pop; a simultaneous write and pop at full is legal.
- Status flags (empty, full, afull, numel) are registered and update the cycle after the causing write or pop.
- Reset mid-stream: the word is discarded and out_valid=0 the following cycle.

Optional Feature:
- Macro DVS_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt, 16 bits.
  - drop_cnt is a saturating count of all dropped words. Several drops in one cycle add their count; it sticks at 16'hFFFF.
  - ovf_clr also zeroes drop_cnt.
- Undefined: port and logic absent; ovf only.

Decomposition:
- Package dvs_fifo_pkg holds:
  - state typedef enum {IDLE, STREAM}
  - function beats(dw, lw) = dw/lw
  - localparam DROP_CNT_W=16
- Sub-module dvs_lane_shifter (load, shift enable, beat counter, out_last) is natural.
- The FIFO memory and multi-write pointer logic stay in the top.

Test Plan:
- Fill and drain: 16 single-channel writes, ch0, word i ending in 8'(i); out_ready=1 -> 16×34 beats, no gaps. Beat 0 of each word is word[135:132]; out_last every 34th beat; empty=1 after the final pop.
- Dual write: wr_en=2'b11 with numel=15 -> ch0 stored, ch1 dropped, ovf=2'b10, numel=16, full=1. A pulse of ovf_clr then gives ovf=0.
- Backpressure: out_ready toggled 1/0 each cycle -> out_data stable while not ready; words are bit-exact after reassembly; out_ch matches the writer.
- Simultaneous pop and write at full: stream the last beat of a word while wr_en=2'b01 with numel=16 -> write dropped (free computed pre-pop), numel=15.
- Wrap-around: 40 writes interleaved with draining keeps numel<=8 -> pointer wrap is correct and order preserved; afull asserts exactly when numel reaches 12.
- Reset mid-stream at beat 10 -> next cycle out_valid=0, numel=0, empty=1, ovf=0. With DVS_FIFO_DROP_CNT_EN defined, 3 prior drops read as drop_cnt=3 before reset and 0 after.
